sync_up_counter: RTL and testbench
==================================

Name: sync_up_counter

Overview:
- Synchronous, enable-gated, loadable up counter with programmable terminal value (modulus = max_val+1).
- Counterpart of the team's ripple down counter: counts upward, and all stages are clocked by the single system clock (no rippled clocks).
- Drives lab timing/sequence logic. The carry-out (tc) allows cascading several instances into wider counters.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- RST_VAL, 0, value loaded into out on reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
- en  input  1  count enable; out advances by one per clk edge while high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written to out when load=1.
- max_val  input  WIDTH  terminal count; out wraps from max_val to 0.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal count / carry-out, combinational: en & (out >= max_val).
- wrap  output  1  registered one-cycle pulse, high the cycle after out wrapped to 0.

Behaviour:
- Reset: rst=0 at a rising edge gives out=RST_VAL and wrap=0 on that edge. tc follows its equation.
- Reset is not asynchronous. Asserting rst between edges has no effect until the next edge.
- Priority per edge: reset > load > en > hold.
- Load: out <= load_val; wrap <= 0. This applies regardless of en and of whether load_val > max_val.
- Count, when en=1 and load=0:
  - if out >= max_val: out <= 0, wrap <= 1;
  - else: out <= out+1, wrap <= 0.
- Hold, when en=0 and load=0: out unchanged; wrap <= 0.
- Latency: out changes one edge after en/load is sampled. tc is same-cycle combinational, so an upstream counter's tc can drive a downstream counter's en (cascade).
- Out-of-range case: if out > max_val (after a load, or after max_val is lowered), the next enabled edge wraps to 0. The counter never walks past max_val towards 2^WIDTH-1.
- max_val=0: out stays 0 while enabled; tc=en; wrap pulses every enabled cycle.
- max_val=2^WIDTH-1: full binary count. The wrap from all-ones to 0 uses natural overflow.
- Arithmetic: unsigned, WIDTH bits, no sign extension. Comparisons are unsigned.
- Simultaneous load and en: load wins. No increment is applied to load_val in that cycle.
- Reset mid-count: the count is lost and out = RST_VAL next cycle. A wrap pulse pending for that edge is suppressed (wrap=0).

Optional Feature:
- Macro: SYNC_UP_COUNTER_SAT_EN.
- Defined: saturating mode. When out >= max_val and en=1, out holds (set to max_val if it was above it). wrap is never asserted (tied 0). tc remains en & (out >= max_val).
- Undefined: wrapping behaviour as specified above.

Decomposition:
- Shared package/include holds:
  - counter default constants CNT_WIDTH_DEF=4 and CNT_RST_VAL_DEF=0;
  - priority-encoding localparams for next-state select: SEL_HOLD, SEL_LOAD, SEL_INC, SEL_WRAP.
- Natural sub-module: cnt_next_state. It is combinational and takes out, en, load, load_val and max_val. It produces next_out and next_wrap, so it can be unit-tested separately.
- The top-level block holds only the registers and the tc equation.

Test Plan:
- Reset: WIDTH=4, rst=0 for 2 edges, then rst=1 with en=0 -> out=0, wrap=0, tc=0. RST_VAL=5 gives out=5.
- Free count: max_val=15, en=1 for 17 edges -> out 0..15, then 0, 1. tc=1 only while out=15. wrap=1 for exactly the one cycle after out becomes 0.
- Modulus: max_val=9, en=1 -> out sequence 0..9, 0. Drop en for 3 cycles at out=4 -> out holds 4 and tc=0.
- Load priority: out=3, load=1, load_val=12, en=1, max_val=9 -> out=12 next edge (no increment). Next enabled edge -> out=0, wrap=1.
- Mid-operation reset: out=7, en=1, rst=0 for one edge -> out=RST_VAL. rst pulse with no clk edge -> no change.
- Cascade: two instances, low instance tc feeding high instance en, both max_val=15 -> high out increments when low goes 15->0. Combined value 0x0F -> 0x10. Repeat with SYNC_UP_COUNTER_SAT_EN defined -> low saturates at 15, wrap stays 0.

Source files
------------

// File: rtl/sync_up_counter_pkg.sv
// Purpose: shared constants and next-state select encoding for sync_up_counter.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package sync_up_counter_pkg;

    localparam int          CNT_WIDTH_DEF   = 4;
    localparam int unsigned CNT_RST_VAL_DEF = 0;

    // Which source feeds the count register on the next edge.
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_HOLD = 2'd0;
    localparam sel_t SEL_LOAD = 2'd1;
    localparam sel_t SEL_INC  = 2'd2;
    localparam sel_t SEL_WRAP = 2'd3;

    // Priority: load > count > hold. Reset is handled by the register itself.
    // at_top covers both out==max_val and out>max_val (after a load or when
    // max_val is lowered), so the count can never walk past the terminal value.
    function automatic sel_t sel_next(input logic load, input logic en, input logic at_top);
        sel_t sel;
        if (load) begin
            sel = SEL_LOAD;
        end else if (en) begin
            sel = at_top ? SEL_WRAP : SEL_INC;
        end else begin
            sel = SEL_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sync_up_counter_if.sv
// Purpose: control/status bundle between a counter and whoever drives it.
// Latency: n/a (wiring only). Backpressure: none, the counter accepts every cycle.
// Signals: en, load, load_val, max_val (master -> counter); out, tc, wrap (counter -> master).
interface sync_up_counter_if
    import sync_up_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             wrap;

    modport master (
        output en, load, load_val, max_val,
        input  out, tc, wrap
    );

    modport slave (
        input  en, load, load_val, max_val,
        output out, tc, wrap
    );
endinterface

// File: rtl/sync_up_counter_cnt_next_state.sv
// Purpose: combinational next-count / next-wrap decode for sync_up_counter.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_out, i_en, i_load, i_load_val, i_max_val -> o_next_out, o_next_wrap.
// SYNC_UP_COUNTER_SAT_EN: when defined, the terminal case clamps at max_val and never wraps.
module sync_up_counter_cnt_next_state
    import sync_up_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_out,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_max_val,
    output logic [WIDTH-1:0] o_next_out,
    output logic             o_next_wrap
);

    logic w_at_top;
    sel_t w_sel;

    assign w_at_top = (i_out >= i_max_val);
    assign w_sel    = sel_next(i_load, i_en, w_at_top);

    always_comb begin
        o_next_out  = i_out;
        o_next_wrap = 1'b0;
        case (w_sel)
            SEL_LOAD: o_next_out = i_load_val;
            SEL_INC:  o_next_out = i_out + WIDTH'(1);
            SEL_WRAP: begin
`ifdef SYNC_UP_COUNTER_SAT_EN
                // Clamp: also pulls an above-range value back down to max_val.
                o_next_out  = i_max_val;
`else
                o_next_out  = '0;
                o_next_wrap = 1'b1;
`endif
            end
            default: begin
                o_next_out  = i_out;
                o_next_wrap = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sync_up_counter.sv
// Purpose: enable-gated, loadable up counter with programmable terminal value; tc cascades.
// Latency: out/wrap update one clk edge after en/load are sampled; tc is same-cycle combinational.
// Backpressure: none; clk, rst (sync, active-low) plus cnt_if (slave) carrying en/load/load_val/max_val/out/tc/wrap.
// SYNC_UP_COUNTER_SAT_EN: saturating mode (holds at max_val, wrap tied low).
module sync_up_counter
    import sync_up_counter_pkg::*;
#(
    parameter int          WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned RST_VAL = CNT_RST_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sync_up_counter_if.slave cnt_if
);

    localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_out;
    logic             w_next_wrap;

    sync_up_counter_cnt_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_out       (r_out),
        .i_en        (cnt_if.en),
        .i_load      (cnt_if.load),
        .i_load_val  (cnt_if.load_val),
        .i_max_val   (cnt_if.max_val),
        .o_next_out  (w_next_out),
        .o_next_wrap (w_next_wrap)
    );

    // Reset beats everything, including a wrap that would otherwise fire this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out  <= RST_VAL_W;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_next_out;
            r_wrap <= w_next_wrap;
        end
    end

    assign cnt_if.out  = r_out;
    assign cnt_if.wrap = r_wrap;
    // Combinational so an upstream tc can gate a downstream en in the same cycle.
    assign cnt_if.tc   = cnt_if.en & (r_out >= cnt_if.max_val);

endmodule

// File: tb/tb_sync_up_counter.sv
module tb_sync_up_counter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_up_counter_if #(.WIDTH(4)) lo_if ();
    sync_up_counter_if #(.WIDTH(4)) hi_if ();
    sync_up_counter_if #(.WIDTH(4)) r5_if ();

    sync_up_counter #(.WIDTH(4), .RST_VAL(0)) u_lo (.clk(clk), .rst(rst), .cnt_if(lo_if.slave));
    sync_up_counter #(.WIDTH(4), .RST_VAL(0)) u_hi (.clk(clk), .rst(rst), .cnt_if(hi_if.slave));
    sync_up_counter #(.WIDTH(4), .RST_VAL(5)) u_r5 (.clk(clk), .rst(rst), .cnt_if(r5_if.slave));

    // High digit of the cascade counts whenever the low digit's tc is high.
    assign hi_if.en       = lo_if.tc;
    assign hi_if.load     = 1'b0;
    assign hi_if.load_val = 4'h0;
    assign hi_if.max_val  = 4'hF;

    // Idle instance: only its reset value is of interest.
    assign r5_if.en       = 1'b0;
    assign r5_if.load     = 1'b0;
    assign r5_if.load_val = 4'h0;
    assign r5_if.max_val  = 4'hF;

    typedef struct {
        int         idx;
        logic [3:0] eo;
        logic       ew;
        logic       etc;
        logic       chk_hi;
        logic [3:0] ehi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_n   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", nm, idx, act, req);
        end
    endtask

    // Drive one vector shortly after a rising edge; the result is visible after the next edge.
    // glitch: pulse rst low and back high between edges (must not affect anything).
    task automatic apply(input int r, input int e, input int l, input int ld, input int mx,
                         input int glitch, input int eo, input int ew, input int etc,
                         input int chk_hi, input int ehi);
        exp_t x;
        @(posedge clk);
        #2;
        rst             = (r != 0);
        lo_if.en        = (e != 0);
        lo_if.load      = (l != 0);
        lo_if.load_val  = 4'(ld);
        lo_if.max_val   = 4'(mx);
        if (glitch != 0) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
        end
        x.idx    = vec_n;
        x.eo     = 4'(eo);
        x.ew     = (ew != 0);
        x.etc    = (etc != 0);
        x.chk_hi = (chk_hi != 0);
        x.ehi    = 4'(ehi);
        sb.push_back(x);
        vec_n++;
    endtask

    // Monitor: one result per clock; compare whenever an expectation is pending.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            chk("out",    mon_x.idx, 32'(lo_if.out),  32'(mon_x.eo));
            chk("wrap",   mon_x.idx, 32'(lo_if.wrap), 32'(mon_x.ew));
            chk("tc",     mon_x.idx, 32'(lo_if.tc),   32'(mon_x.etc));
            chk("r5_out", mon_x.idx, 32'(r5_if.out),  32'd5);
            if (mon_x.chk_hi) begin
                chk("hi_out", mon_x.idx, 32'(hi_if.out), 32'(mon_x.ehi));
            end
        end
    end

    initial begin
        rst            = 1'b0;
        lo_if.en       = 1'b0;
        lo_if.load     = 1'b0;
        lo_if.load_val = 4'h0;
        lo_if.max_val  = 4'hF;

        // Reset held for two edges, then released with en low.
        //     r  e  l  ld  mx  g   eo ew tc  hi ehi
        apply(0, 0, 0, 0, 15, 0,  0, 0, 0,  1, 0);
        apply(0, 0, 0, 0, 15, 0,  0, 0, 0,  1, 0);
        apply(1, 0, 0, 0, 15, 0,  0, 0, 0,  1, 0);

        // Free count over the full range; high digit steps when low goes 15 -> 0.
        for (int i = 1; i <= 17; i++) begin
`ifdef SYNC_UP_COUNTER_SAT_EN
            apply(1, 1, 0, 0, 15, 0, (i <= 15) ? i : 15, 0, int'(i >= 15), 1, (i >= 16) ? i - 15 : 0);
`else
            apply(1, 1, 0, 0, 15, 0, i % 16, int'(i == 16), int'(i == 15), 1, (i >= 16) ? 1 : 0);
`endif
        end

`ifdef SYNC_UP_COUNTER_SAT_EN
        // Above-range load clamps to max_val; max_val=0 clamps to 0.
        apply(1, 0, 1, 12, 9, 0, 12, 0, 0, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  9, 0, 1, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  9, 0, 1, 0, 0);
        apply(1, 1, 0, 0,  0, 0,  0, 0, 1, 0, 0);
        // Load wins over en.
        apply(1, 0, 1, 3,  9, 0,  3, 0, 0, 0, 0);
        apply(1, 1, 1, 12, 9, 0, 12, 0, 1, 0, 0);
        // Normal count up to the ceiling.
        apply(1, 0, 1, 7,  9, 0,  7, 0, 0, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  8, 0, 0, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  9, 0, 1, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  9, 0, 1, 0, 0);
        // Mid-count reset.
        apply(0, 1, 0, 0,  9, 0,  0, 0, 0, 0, 0);
`else
        // Modulus 10, with en dropped for three cycles at 4.
        apply(1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 14; j++) begin
            apply(1, 1, 0, 0, 9, 0, j % 10, int'(j == 10), int'(j == 9), 0, 0);
        end
        repeat (3) apply(1, 0, 0, 0, 9, 0, 4, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 9, 0, 5, 0, 0, 0, 0);
        // Load beats en, no increment; next enabled edge wraps from above range.
        apply(1, 0, 1, 3,  9, 0,  3, 0, 0, 0, 0);
        apply(1, 1, 1, 12, 9, 0, 12, 0, 1, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  0, 1, 0, 0, 0);
        apply(1, 1, 0, 0,  9, 0,  1, 0, 0, 0, 0);
        // max_val lowered below current count.
        apply(1, 0, 1, 7,  9, 0,  7, 0, 0, 0, 0);
        apply(1, 1, 0, 0,  5, 0,  0, 1, 0, 0, 0);
        // Mid-count reset; reset also swallows a wrap due on that edge.
        apply(1, 0, 1, 7,  15, 0,  7, 0, 0, 0, 0);
        apply(0, 1, 0, 0,  15, 0,  0, 0, 0, 0, 0);
        apply(1, 0, 1, 15, 15, 0, 15, 0, 0, 0, 0);
        apply(0, 1, 0, 0,  15, 0,  0, 0, 0, 0, 0);
        // max_val = 0: stays at 0, tc = en, wrap every enabled cycle.
        apply(1, 0, 1, 6, 15, 0, 6, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0);
        apply(1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0);
        apply(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // Load above max with en low, then wrap.
        apply(1, 0, 1, 14, 3, 0, 14, 0, 0, 0, 0);
        apply(1, 1, 0, 0,  3, 0,  0, 1, 0, 0, 0);
        // All-ones to zero at full modulus.
        apply(1, 1, 1, 15, 15, 0, 15, 0, 1, 0, 0);
        apply(1, 1, 0, 0,  15, 0,  0, 1, 0, 0, 0);
`endif
        // Reset pulse between edges has no effect.
        apply(1, 0, 1, 6, 15, 0, 6, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 15, 1, 6, 0, 0, 0, 0);

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #3;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
